// File: rtl/vga_timing_pkg.sv
// Shared helpers for the VGA timing generator: axis length arithmetic and the
// sync polarity type. Used by vga_timing_gen and vga_axis_counter.
package vga_timing_pkg;

    typedef logic pol_t;

    function automatic int total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // First count of the sync pulse on an axis (inclusive).
    function automatic int sync_lo(input int active, input int fp);
        return active + fp;
    endfunction

    // First count after the sync pulse on an axis (exclusive bound).
    function automatic int sync_hi(input int active, input int fp, input int sync);
        return active + fp + sync;
    endfunction

endpackage

// File: rtl/vga_timing_if.sv
// Video timing bundle between the timing generator (master) and the pixel
// formatter (slave). frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_if #(
    parameter int H_BITS = 8,
    parameter int V_BITS = 7
);
    // pix_ce is a strobe, not a handshake: the master samples it every clk and
    // each high cycle advances one pixel; outputs reflect it one clk later.
    logic              pix_ce;
    logic              h_sync;
    logic              v_sync;
    logic              disp_ena;
    logic              n_blank;
    logic              n_sync;
    logic [H_BITS-1:0] col;
    logic [V_BITS-1:0] row;
    logic              line_start;
    logic              frame_start;
`ifdef VGA_FRAME_CNT_EN
    logic [15:0]       frame_cnt;
`endif

    modport master (
        input  pix_ce,
        output h_sync, v_sync, disp_ena, n_blank, n_sync,
        output col, row, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
        , output frame_cnt
`endif
    );

    modport slave (
        output pix_ce,
        input  h_sync, v_sync, disp_ena, n_blank, n_sync,
        input  col, row, line_start, frame_start
`ifdef VGA_FRAME_CNT_EN
        , input frame_cnt
`endif
    );

endinterface

// File: rtl/vga_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping position counter plus
// combinational region decodes of the current count.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int ACTIVE = 4,
    parameter int FP     = 1,
    parameter int SYNC   = 2,
    parameter int BP     = 1,
    parameter int BITS   = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    output logic [BITS-1:0] cnt,
    output logic            wrap,
    output logic            in_active,
    output logic            in_sync
);

    localparam logic [BITS-1:0] LAST    = BITS'(total(ACTIVE, FP, SYNC, BP) - 1);
    localparam logic [BITS-1:0] ACT_END = BITS'(ACTIVE);
    localparam logic [BITS-1:0] SYN_LO  = BITS'(sync_lo(ACTIVE, FP));
    localparam logic [BITS-1:0] SYN_HI  = BITS'(sync_hi(ACTIVE, FP, SYNC));

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
        end
    end

    assign wrap      = (cnt == LAST);
    assign in_active = (cnt < ACT_END);
    assign in_sync   = (cnt >= SYN_LO) && (cnt < SYN_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator advancing on pix_ce, with registered
// sync/blank/position outputs. Optional frame counter: VGA_FRAME_CNT_EN.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = 150,
    parameter int   H_FP     = 9,
    parameter int   H_SYNC   = 15,
    parameter int   H_BP     = 24,
    parameter int   V_ACTIVE = 75,
    parameter int   V_FP     = 3,
    parameter int   V_SYNC   = 3,
    parameter int   V_BP     = 3,
    parameter pol_t H_POL    = 1'b0,
    parameter pol_t V_POL    = 1'b1,
    parameter int   H_BITS   = $clog2(H_ACTIVE + H_FP + H_SYNC + H_BP),
    parameter int   V_BITS   = $clog2(V_ACTIVE + V_FP + V_SYNC + V_BP)
) (
    input logic         clk,
    input logic         rst,
    vga_timing_if.master vga
);

    localparam int H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_len
        $error("vga_timing_gen: active, porch and sync lengths must all be >= 1");
    end
    if (((H_TOTAL - 1) >> H_BITS) != 0 || ((V_TOTAL - 1) >> V_BITS) != 0) begin : g_bad_bits
        $error("vga_timing_gen: H_BITS/V_BITS too narrow for H_TOTAL-1/V_TOTAL-1");
    end

    logic              pix_ce;
    logic [H_BITS-1:0] h_cnt;
    logic [V_BITS-1:0] v_cnt;
    logic              h_wrap, h_act, h_syn;
    logic              v_wrap, v_act, v_syn;

    assign pix_ce = vga.pix_ce;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .BITS(H_BITS)
    ) u_h_axis (
        .clk(clk), .rst(rst), .inc(pix_ce),
        .cnt(h_cnt), .wrap(h_wrap), .in_active(h_act), .in_sync(h_syn)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .BITS(V_BITS)
    ) u_v_axis (
        .clk(clk), .rst(rst), .inc(pix_ce && h_wrap),
        .cnt(v_cnt), .wrap(v_wrap), .in_active(v_act), .in_sync(v_syn)
    );

    logic              h_sync_q, v_sync_q, disp_ena_q, n_sync_q;
    logic              line_start_q, frame_start_q;
    logic [H_BITS-1:0] col_q;
    logic [V_BITS-1:0] row_q;

    // Outputs are decoded from the pre-increment counts, so they trail the
    // strobe that consumed that position by one clk.
    always_ff @(posedge clk) begin
        if (!rst) begin
            h_sync_q      <= ~H_POL;
            v_sync_q      <= ~V_POL;
            disp_ena_q    <= 1'b0;
            n_sync_q      <= 1'b1;
            col_q         <= '0;
            row_q         <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (pix_ce) begin
                h_sync_q      <= h_syn ? H_POL : ~H_POL;
                v_sync_q      <= v_syn ? V_POL : ~V_POL;
                disp_ena_q    <= h_act && v_act;
                n_sync_q      <= ~(h_syn || v_syn);
                line_start_q  <= (h_cnt == '0);
                frame_start_q <= (h_cnt == '0) && (v_cnt == '0);
                if (h_act) col_q <= h_cnt;
                if (v_act) row_q <= v_cnt;
            end
        end
    end

    assign vga.h_sync      = h_sync_q;
    assign vga.v_sync      = v_sync_q;
    assign vga.disp_ena    = disp_ena_q;
    assign vga.n_blank     = disp_ena_q;
    assign vga.n_sync      = n_sync_q;
    assign vga.col         = col_q;
    assign vga.row         = row_q;
    assign vga.line_start  = line_start_q;
    assign vga.frame_start = frame_start_q;

`ifdef VGA_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Bumps on the last pixel of a frame, alongside the wrap to (0,0).
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_cnt_q <= '0;
        end else if (pix_ce && h_wrap && v_wrap) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign vga.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed-size VGA timing generator. All horizontal/vertical active, porch and sync lengths and both sync polarities are set by parameters. Counters advance only on a pixel-clock-enable strobe, and the block adds line-start and frame-start pulses. It sits between the system clock domain and the pixel formatter, which consumes col/row/disp_ena.

Parameters:
H_ACTIVE, 150, visible pixels per line (>=1)
H_FP, 9, horizontal front porch in pixels (>=1)
H_SYNC, 15, horizontal sync width in pixels (>=1)
H_BP, 24, horizontal back porch in pixels (>=1)
V_ACTIVE, 75, visible lines per frame (>=1)
V_FP, 3, vertical front porch in lines (>=1)
V_SYNC, 3, vertical sync width in lines (>=1)
V_BP, 3, vertical back porch in lines (>=1)
H_POL, 0, active level of h_sync
V_POL, 1, active level of v_sync
H_BITS, $clog2(H_ACTIVE+H_FP+H_SYNC+H_BP), width of col and the horizontal counter
V_BITS, $clog2(V_ACTIVE+V_FP+V_SYNC+V_BP), width of row and the vertical counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-low (rst==0 resets on posedge clk)
pix_ce  in  1  pixel strobe; counters and outputs update only when 1
h_sync  out  1  horizontal sync, registered, polarity H_POL
v_sync  out  1  vertical sync, registered, polarity V_POL
disp_ena  out  1  1 when the current pixel is in the active area
n_blank  out  1  equal to disp_ena
n_sync  out  1  composite sync, active-low: 0 while either sync is active
col  out  H_BITS  active-area column
row  out  V_BITS  active-area row
line_start  out  1  one-cycle pulse at h_cnt==0
frame_start  out  1  one-cycle pulse at h_cnt==0 && v_cnt==0

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way. Each line is ordered active, FP, SYNC, BP, starting at count 0.
- Internal h_cnt (0..H_TOTAL-1) and v_cnt (0..V_TOTAL-1). On a pix_ce cycle, h_cnt increments.
  - When h_cnt == H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments.
  - When v_cnt also == V_TOTAL-1, v_cnt wraps to 0.
- All outputs are registered. On a pix_ce cycle they are computed from the pre-increment (h_cnt, v_cnt). Output latency is 1 clk after the strobe.
  - disp_ena = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - h_sync active iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC. v_sync uses the same rule on the vertical axis.
  - col updates to h_cnt only when h_cnt < H_ACTIVE, otherwise it holds. row updates to v_cnt only when v_cnt < V_ACTIVE, otherwise it holds.
  - line_start = (h_cnt==0). frame_start = (h_cnt==0 && v_cnt==0).
- When pix_ce==0: counters, syncs, disp_ena, col and row hold; line_start and frame_start are driven 0.
- Reset values (rst==0), taking priority over pix_ce:
  - h_cnt=0, v_cnt=0, col=0, row=0.
  - disp_ena=0, n_blank=0.
  - h_sync=~H_POL, v_sync=~V_POL, n_sync=1.
  - line_start=0, frame_start=0.
- Reset mid-frame restarts at (0,0). The first pix_ce after reset release produces disp_ena=1, col=0, row=0, line_start=1 and frame_start=1.
- Elaboration check: $error if any porch or sync parameter is 0, or if H_BITS/V_BITS cannot hold H_TOTAL-1/V_TOTAL-1.

Optional Feature:
VGA_FRAME_CNT_EN: when defined, adds output frame_cnt (16 bits).
- Reset value 0.
- Increments, wrapping at 2^16, on every pix_ce cycle where v_cnt==V_TOTAL-1 and h_cnt==H_TOTAL-1, so it updates together with the frame_start-producing wrap.
- When undefined, the port and its logic are absent and the block behaves identically otherwise.

Decomposition:
- Package vga_timing_pkg: function total(active,fp,sync,bp), function sync_lo/sync_hi boundary helpers, and a typedef for polarity.
- One sub-module, vga_axis_counter, instantiated twice: horizontal (inc=pix_ce) and vertical (inc=pix_ce && h_wrap).
  - Parameters: ACTIVE/FP/SYNC/BP/BITS.
  - Outputs: cnt, wrap, in_active, in_sync (combinational from cnt).
- The top level owns all output registers.

Test Plan:
Use H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), H_POL=0, V_POL=1, and pix_ce=1 continuously unless noted.
1. Reset then release, pix_ce=1 -> first output cycle: disp_ena=1, col=0, row=0, line_start=1, frame_start=1. frame_start recurs every 48 cycles.
2. First line -> h_sync=0 on output cycles 6-7 (h_cnt 5,6), otherwise 1. disp_ena=1 on cycles 1-4. col holds 3 on cycles 5-8.
3. Full frame -> v_sync=1 for the 8 cycles of line 4. row sequences 0,1,2 and holds 2 during lines 3-5. n_sync=0 exactly when either sync is active.
4. pix_ce toggling 1,0,1,0 -> outputs change only after pix_ce=1 cycles. line_start is never high for two consecutive clks.
5. Assert rst=0 at h_cnt=5, v_cnt=2 -> next clk: all outputs at reset values. After release, frame_start=1 on the first pix_ce.
6. With VGA_FRAME_CNT_EN, run 3 frames -> frame_cnt=3. Force the initial value to 16'hFFFF -> frame_cnt wraps to 0.
